// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - Round-robin arbiter sharing one UART TX among byte requesters
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_par_en,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic                          tx_data_valid,
    output logic [DATA_WIDTH-1:0]         tx_p_data,
    output logic                          tx_par_en,
    input  logic                          tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          arb_busy,
    output logic                          timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_next;
    logic [IDX_W-1:0]     last_grant;
    logic [IDX_W-1:0]     last_next;
    logic [IDX_W-1:0]     grant_next;
    logic [DATA_WIDTH-1:0] data_next;
    logic                 par_next;
    logic [NUM_REQ-1:0]   ack_next;
    logic                 dv_next;
    logic                 tmo_next;
    logic                 any_valid;
    logic [IDX_W-1:0]     winner;

    // Round-robin pick: the nearest valid requester after last_grant wins.
    // Scanning from the farthest offset down lets the closest one overwrite.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
                any_valid = 1'b1;
                winner    = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            end
        end
    end

    // Next-state and next registered output values.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        last_next  = last_grant;
        grant_next = grant_id;
        data_next  = tx_p_data;
        par_next   = tx_par_en;
        ack_next   = '0;
        dv_next    = 1'b0;
        tmo_next   = 1'b0;
        case (state)
            IDLE: begin
                // A busy TX (foreign frame or stale one) blocks any new grant.
                if (any_valid && !tx_busy) begin
                    state_next       = ISSUE;
                    last_next        = winner;
                    grant_next       = winner;
                    data_next        = req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                    par_next         = req_par_en[winner];
                    ack_next[winner] = 1'b1;
                    dv_next          = 1'b1;
                end
            end
            ISSUE: begin
                state_next = WAIT_BUSY;
                cnt_next   = '0;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    state_next = IDLE;
                    tmo_next   = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, round-robin pointer and all outputs are registered together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            last_grant    <= IDX_W'(NUM_REQ - 1);
            grant_id      <= '0;
            tx_p_data     <= '0;
            tx_par_en     <= 1'b0;
            req_ack       <= '0;
            tx_data_valid <= 1'b0;
            timeout_err   <= 1'b0;
            arb_busy      <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            last_grant    <= last_next;
            grant_id      <= grant_next;
            tx_p_data     <= data_next;
            tx_par_en     <= par_next;
            req_ack       <= ack_next;
            tx_data_valid <= dv_next;
            timeout_err   <= tmo_next;
            arb_busy      <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - Directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_par_en;
    logic [3:0]  req_ack;
    logic        tx_data_valid;
    logic [7:0]  tx_p_data;
    logic        tx_par_en;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        arb_busy;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(
        .NUM_REQ(4),
        .DATA_WIDTH(8),
        .BUSY_TIMEOUT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_par_en(req_par_en),
        .req_ack(req_ack),
        .tx_data_valid(tx_data_valid),
        .tx_p_data(tx_p_data),
        .tx_par_en(tx_par_en),
        .tx_busy(tx_busy),
        .grant_id(grant_id),
        .arb_busy(arb_busy),
        .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset      = 1'b0;
        req_valid  = 4'b0000;
        req_data   = 32'h0;
        req_par_en = 4'b0000;
        tx_busy    = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if ({req_ack, tx_data_valid, tx_p_data, tx_par_en, grant_id, arb_busy, timeout_err} !== 18'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0",
                     {req_ack, tx_data_valid, tx_p_data, tx_par_en, grant_id, arb_busy, timeout_err});
        end
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (arb_busy !== 1'b0 || tx_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b dv=%b exp 0 0", arb_busy, tx_data_valid);
        end
    endtask

    task automatic test_single;
        do_reset();
        req_valid      = 4'b0100;
        req_data[23:16] = 8'hA5;
        req_par_en     = 4'b0100;
        tick();
        checks++;
        if (tx_data_valid !== 1'b1 || req_ack !== 4'b0100 || tx_p_data !== 8'hA5 ||
            tx_par_en !== 1'b1 || grant_id !== 2'd2 || arb_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant got dv=%b ack=%b data=%h par=%b id=%0d busy=%b exp 1 0100 a5 1 2 1",
                     tx_data_valid, req_ack, tx_p_data, tx_par_en, grant_id, arb_busy);
        end
        req_valid = 4'b0000;
        tick();
        checks++;
        if (tx_data_valid !== 1'b0 || req_ack !== 4'b0000) begin
            errors++;
            $display("FAIL single_pulse_width got dv=%b ack=%b exp 0 0000", tx_data_valid, req_ack);
        end
        tx_busy = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (arb_busy !== 1'b1 || tx_data_valid !== 1'b0 || tx_p_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_frame got busy=%b dv=%b data=%h exp 1 0 a5", arb_busy, tx_data_valid, tx_p_data);
        end
        tx_busy = 1'b0;
        tick();
        checks++;
        if (arb_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_release got busy=%b exp 0", arb_busy);
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] e;
        logic [3:0] ea;
        do_reset();
        req_data   = 32'h13121110;
        req_par_en = 4'b0000;
        req_valid  = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            e  = 2'(f % 4);
            ea = 4'b0001 << e;
            tick();
            checks++;
            if (tx_data_valid !== 1'b1 || grant_id !== e || req_ack !== ea || tx_p_data !== (8'h10 + 8'(e))) begin
                errors++;
                $display("FAIL rr_grant%0d got dv=%b id=%0d ack=%b data=%h exp 1 %0d %b %h",
                         f, tx_data_valid, grant_id, req_ack, tx_p_data, e, ea, 8'h10 + 8'(e));
            end
            tick();
            tx_busy = 1'b1;
            tick();
            tick();
            checks++;
            if (tx_data_valid !== 1'b0 || req_ack !== 4'b0000 || tx_p_data !== (8'h10 + 8'(e))) begin
                errors++;
                $display("FAIL rr_busy%0d got dv=%b ack=%b data=%h exp 0 0000 %h",
                         f, tx_data_valid, req_ack, tx_p_data, 8'h10 + 8'(e));
            end
            tx_busy = 1'b0;
            tick();
            checks++;
            if (arb_busy !== 1'b0 || tx_data_valid !== 1'b0 || grant_id !== e) begin
                errors++;
                $display("FAIL rr_idle%0d got busy=%b dv=%b id=%0d exp 0 0 %0d", f, arb_busy, tx_data_valid, grant_id, e);
            end
        end
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_parity;
        do_reset();
        req_data   = 32'h0000AA55;
        req_par_en = 4'b0101;
        req_valid  = 4'b0011;
        for (int f = 0; f < 2; f++) begin
            tick();
            checks++;
            if (grant_id !== 2'(f) || tx_par_en !== (f == 0)) begin
                errors++;
                $display("FAIL par_grant%0d got id=%0d par=%b exp %0d %b", f, grant_id, tx_par_en, f, f == 0);
            end
            tick();
            tx_busy = 1'b1;
            for (int c = 0; c < 3; c++) begin
                tick();
                checks++;
                if (tx_par_en !== (f == 0)) begin
                    errors++;
                    $display("FAIL par_hold%0d_%0d got %b exp %b", f, c, tx_par_en, f == 0);
                end
            end
            tx_busy = 1'b0;
            tick();
        end
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_timeout;
        do_reset();
        req_data  = 32'h44332211;
        req_valid = 4'b0001;
        tick();
        checks++;
        if (tx_data_valid !== 1'b1 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL tmo_grant got dv=%b id=%0d exp 1 0", tx_data_valid, grant_id);
        end
        req_valid = 4'b0011;
        tick();
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (timeout_err !== 1'b0 || arb_busy !== 1'b1) begin
                errors++;
                $display("FAIL tmo_wait%0d got err=%b busy=%b exp 0 1", c, timeout_err, arb_busy);
            end
        end
        tick();
        checks++;
        if (timeout_err !== 1'b1 || arb_busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_pulse got err=%b busy=%b exp 1 0", timeout_err, arb_busy);
        end
        tick();
        checks++;
        if (timeout_err !== 1'b0 || tx_data_valid !== 1'b1 || grant_id !== 2'd1 || tx_p_data !== 8'h22) begin
            errors++;
            $display("FAIL tmo_next got err=%b dv=%b id=%0d data=%h exp 0 1 1 22",
                     timeout_err, tx_data_valid, grant_id, tx_p_data);
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_reset_mid_frame;
        do_reset();
        req_data  = 32'h0077003C;
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b0000;
        tick();
        tx_busy = 1'b1;
        tick();
        tick();
        req_valid = 4'b0001;
        reset     = 1'b0;
        #1;
        checks++;
        if ({req_ack, tx_data_valid, tx_p_data, tx_par_en, grant_id, arb_busy, timeout_err} !== 18'h0) begin
            errors++;
            $display("FAIL midrst_async got %h exp 0",
                     {req_ack, tx_data_valid, tx_p_data, tx_par_en, grant_id, arb_busy, timeout_err});
        end
        #2;
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (tx_data_valid !== 1'b0 || req_ack !== 4'b0000 || arb_busy !== 1'b0) begin
                errors++;
                $display("FAIL midrst_hold%0d got dv=%b ack=%b busy=%b exp 0 0000 0", c, tx_data_valid, req_ack, arb_busy);
            end
        end
        tx_busy = 1'b0;
        tick();
        checks++;
        if (tx_data_valid !== 1'b1 || grant_id !== 2'd0 || req_ack !== 4'b0001 || tx_p_data !== 8'h3C) begin
            errors++;
            $display("FAIL midrst_grant got dv=%b id=%0d ack=%b data=%h exp 1 0 0001 3c",
                     tx_data_valid, grant_id, req_ack, tx_p_data);
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_foreign_busy;
        do_reset();
        req_data   = 32'h00006600;
        req_par_en = 4'b0010;
        tx_busy    = 1'b1;
        req_valid  = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (tx_data_valid !== 1'b0 || req_ack !== 4'b0000 || arb_busy !== 1'b0) begin
                errors++;
                $display("FAIL foreign_hold%0d got dv=%b ack=%b busy=%b exp 0 0000 0", c, tx_data_valid, req_ack, arb_busy);
            end
        end
        tx_busy = 1'b0;
        tick();
        checks++;
        if (tx_data_valid !== 1'b1 || req_ack !== 4'b0010 || grant_id !== 2'd1 ||
            tx_p_data !== 8'h66 || tx_par_en !== 1'b1) begin
            errors++;
            $display("FAIL foreign_grant got dv=%b ack=%b id=%0d data=%h par=%b exp 1 0010 1 66 1",
                     tx_data_valid, req_ack, grant_id, tx_p_data, tx_par_en);
        end
        req_valid = 4'b0000;
    endtask

    initial begin
        reset      = 1'b0;
        req_valid  = 4'b0000;
        req_data   = 32'h0;
        req_par_en = 4'b0000;
        tx_busy    = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_parity();
        test_timeout();
        test_reset_mid_frame();
        test_foreign_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
